uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmitter (8 data bits, even parity, 1 stop; send/busy handshake) among N_REQ byte producers.
- Sits between the requesters (command echo, status reporter, debug dump, etc.) and the transmitter's send/data_in/busy pins.
- Issues one single-cycle send per byte and waits for the full frame to finish before re-arbitrating.
- Detects a transmitter that never starts.

---
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte
// producers. Each grant issues one send pulse. The arbiter then waits for
// the transmitter to raise busy and drop it again before it re-arbitrates.
// If busy never rises after a send, it flags a start timeout.
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int START_TO = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   req_done,
    output logic               tx_send,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               active,
    output logic               err_start
);
    localparam int CNT_W = $clog2(START_TO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        last;
    logic [CNT_W-1:0]       cnt;
    logic [N_REQ-1:0][7:0]  data_arr;
    logic [ID_W-1:0]        idx;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_found;
    logic                   grant_go;
    logic                   start_to_hit;
    logic                   frame_end;
    logic [N_REQ-1:0]       req_ready_d;
    logic [N_REQ-1:0]       req_done_d;
    logic                   tx_send_d;
    logic                   active_d;
    logic                   err_start_d;

    assign data_arr = req_data;

    // Rotating priority search: first valid requester after the last grant.
    always_comb begin
        idx        = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % N_REQ);
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // A busy transmitter in IDLE (e.g. not yet reset) blocks arbitration.
    assign grant_go     = (state == IDLE) && !tx_busy && pick_found;
    assign start_to_hit = (state == WAIT_START) && !tx_busy && (cnt == CNT_W'(START_TO - 1));
    assign frame_end    = (state == WAIT_DONE) && !tx_busy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (grant_go) state_nxt = ISSUE;
            ISSUE:      state_nxt = WAIT_START;
            WAIT_START: if (tx_busy) state_nxt = WAIT_DONE;
                        else if (start_to_hit) state_nxt = IDLE;
            WAIT_DONE:  if (!tx_busy) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output decode, computed one cycle ahead so every output leaves a flop.
    always_comb begin
        tx_send_d   = grant_go;
        req_ready_d = grant_go ? ({{(N_REQ-1){1'b0}}, 1'b1} << pick_idx) : '0;
        req_done_d  = frame_end ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
        err_start_d = start_to_hit;
        active_d    = (state_nxt != IDLE);
    end

    // Output, grant and timeout-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_send   <= 1'b0;
            req_ready <= '0;
            req_done  <= '0;
            err_start <= 1'b0;
            active    <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            last      <= ID_W'(N_REQ - 1);
            cnt       <= '0;
        end else begin
            tx_send   <= tx_send_d;
            req_ready <= req_ready_d;
            req_done  <= req_done_d;
            err_start <= err_start_d;
            active    <= active_d;
            if (grant_go) begin
                tx_data  <= data_arr[pick_idx];
                grant_id <= pick_idx;
                last     <= pick_idx;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT_START && !tx_busy)
                cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. It drives a small 8E1 transmitter
// model, which shows one line bit per clock and is busy for 11 cycles. A
// force mux lets tx_busy be pinned high or low to test stalls and timeouts.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  req_done;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_start;

    logic        tb_force, force_val;
    logic        mdl_busy;
    logic [10:0] mdl_sh;
    int          mdl_left;
    logic        line_bit;
    logic [10:0] line_log;

    int checks = 0;
    int failures = 0;
    int nsend, ndone, nready, viol;
    logic [31:0] g_log [16];
    logic [31:0] r_log [16];
    logic [31:0] t_log [16];
    logic [31:0] d_log [16];
    int          s_cyc [16];
    int          dn_at [16];

    uart_tx_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .tx_send(tx_send),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .err_start(err_start)
    );

    always #5 clk = ~clk;

    assign tx_busy  = tb_force ? force_val : mdl_busy;
    assign line_bit = mdl_busy ? mdl_sh[0] : 1'b1;

    // Transmitter model: start, 8 data LSB first, even parity, stop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy <= 1'b0;
            mdl_sh   <= '1;
            mdl_left <= 0;
        end else if (!mdl_busy) begin
            if (tx_send && !tb_force) begin
                mdl_busy <= 1'b1;
                mdl_sh   <= {1'b1, ^tx_data, tx_data, 1'b0};
                mdl_left <= 11;
            end
        end else begin
            mdl_sh   <= {1'b1, mdl_sh[10:1]};
            mdl_left <= mdl_left - 1;
            if (mdl_left == 1) mdl_busy <= 1'b0;
        end
    end

    // Capture the line, first bit ending in bit 0.
    always @(negedge clk)
        if (mdl_busy) line_log <= {line_bit, line_log[10:1]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tb_force  = 1'b0;
        force_val = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Observe frames until nf done pulses or the cycle budget runs out.
    task automatic run_frames(input int nf, input bit hold, input int budget);
        logic prev_send;
        prev_send = 1'b0;
        nsend = 0; ndone = 0; nready = 0; viol = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (req_done != '0) begin
                if (ndone < 16) d_log[ndone] = 32'(req_done);
                ndone++;
            end
            if (tx_send) begin
                if (nsend < 16) begin
                    g_log[nsend] = 32'(grant_id);
                    r_log[nsend] = 32'(req_ready);
                    t_log[nsend] = 32'(tx_data);
                    s_cyc[nsend] = c;
                    dn_at[nsend] = ndone;
                end
                nsend++;
            end
            if (req_ready != '0) nready++;
            if (tx_send && (prev_send || tx_busy)) viol++;
            prev_send = tx_send;
            if (!hold) req_valid = req_valid & ~req_ready;
            if (ndone >= nf) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tb_force  = 1'b0;
        force_val = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_send",   32'(tx_send),   0);
        chk("rst_ready",  32'(req_ready), 0);
        chk("rst_done",   32'(req_done),  0);
        chk("rst_data",   32'(tx_data),   0);
        chk("rst_grant",  32'(grant_id),  0);
        chk("rst_active", 32'(active),    0);
        chk("rst_err",    32'(err_start), 0);
        rst_n = 1'b1;

        // Single byte 0xA5 from requester 0.
        req_data  = 32'h4433_22A5;
        req_valid = 4'b0001;
        run_frames(1, 1'b0, 60);
        chk("t1_ndone",   32'(ndone),    1);
        chk("t1_nsend",   32'(nsend),    1);
        chk("t1_latency", 32'(s_cyc[0]), 0);
        chk("t1_data",    t_log[0],      32'hA5);
        chk("t1_ready",   r_log[0],      32'b0001);
        chk("t1_grant",   g_log[0],      0);
        chk("t1_done",    d_log[0],      32'b0001);
        chk("t1_line",    32'(line_log), 32'b10101001010);
        chk("t1_hold",    32'(tx_data),  32'hA5);
        chk("t1_idle",    32'(active),   0);
        chk("t1_viol",    32'(viol),     0);

        // Requesters 1 and 2 together from reset.
        do_reset();
        req_data  = 32'h4433_2211;
        req_valid = 4'b0110;
        run_frames(2, 1'b0, 100);
        chk("t2_ndone", 32'(ndone), 2);
        chk("t2_nsend", 32'(nsend), 2);
        chk("t2_g0",    g_log[0],   1);
        chk("t2_g1",    g_log[1],   2);
        chk("t2_order", 32'(dn_at[1]), 1);
        chk("t2_d0",    d_log[0],   32'b0010);
        chk("t2_d1",    d_log[1],   32'b0100);
        chk("t2_data0", t_log[0],   32'h22);
        chk("t2_data1", t_log[1],   32'h33);
        chk("t2_viol",  32'(viol),  0);

        // Fairness with all four continuously valid.
        do_reset();
        req_valid = 4'b1111;
        run_frames(8, 1'b1, 300);
        req_valid = '0;
        chk("t3_ndone",  32'(ndone),  8);
        chk("t3_nready", 32'(nready), 8);
        chk("t3_viol",   32'(viol),   0);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_grant%0d", k), g_log[k], 32'(k % 4));

        // Start timeout: busy pinned low, requester 3 only.
        tb_force  = 1'b1;
        force_val = 1'b0;
        req_data  = 32'h5A33_2211;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("t4_send",  32'(tx_send),  1);
        chk("t4_grant", 32'(grant_id), 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_err_early", 32'(err_start), 0);
            chk("t4_nosend",    32'(tx_send),   0);
        end
        @(negedge clk);
        chk("t4_err",    32'(err_start), 1);
        chk("t4_active", 32'(active),    0);
        chk("t4_done",   32'(req_done),  0);
        @(negedge clk);
        chk("t4_resend", 32'(tx_send),   1);
        chk("t4_ready",  32'(req_ready), 32'b1000);
        chk("t4_err_off",32'(err_start), 0);
        req_valid = '0;

        // Asynchronous reset in the middle of a frame.
        do_reset();
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t5_send",  32'(tx_send),  1);
        chk("t5_grant", 32'(grant_id), 2);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("t5_busy",   32'(tx_busy), 1);
        chk("t5_active", 32'(active),  1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_r_send",   32'(tx_send),   0);
        chk("t5_r_active", 32'(active),    0);
        chk("t5_r_done",   32'(req_done),  0);
        chk("t5_r_grant",  32'(grant_id),  0);
        chk("t5_r_data",   32'(tx_data),   0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        run_frames(1, 1'b0, 60);
        req_valid = '0;
        chk("t5_win",   g_log[0],  0);
        chk("t5_ndone", 32'(ndone), 1);
        chk("t5_done",  d_log[0],  32'b0001);

        // Busy already high in IDLE blocks arbitration.
        tb_force  = 1'b1;
        force_val = 1'b1;
        req_valid = 4'b0001;
        repeat (3) begin
            @(negedge clk);
            chk("t6_blocked", 32'(tx_send), 0);
            chk("t6_idle",    32'(active),  0);
        end
        tb_force = 1'b0;
        @(negedge clk);
        chk("t6_send",  32'(tx_send),   1);
        chk("t6_ready", 32'(req_ready), 32'b0001);
        req_valid = '0;
        run_frames(1, 1'b0, 60);
        chk("t6_ndone", 32'(ndone), 1);
        chk("t6_done",  d_log[0],   32'b0001);
        chk("t6_nsend", 32'(nsend), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
